// File: rtl/updown_counter_ctrl.sv
// Debounced two-button up/down counter with wrap/saturate arithmetic and
// hold-to-auto-repeat. Each button has its own synchroniser, debouncer and press FSM.
module updown_counter_ctrl #(
  parameter int WIDTH          = 4,
  parameter int STEP           = 1,
  parameter int SATURATE       = 0,
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_CYCLES    = 12500000,
  parameter int REPEAT_CYCLES  = 2500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [WIDTH-1:0] count,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             wrapped,
  output logic             at_max,
  output logic             at_min
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;
  localparam int TMR_W  = (HOLD_W > REP_W) ? HOLD_W : REP_W;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
  localparam logic             RAW_IDLE  = (ACTIVE_LOW != 0);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic [1:0] raw;
  logic [1:0] ev;

  assign raw = {btn_down, btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             s1_q, s2_q, lvl;
    logic             db_q, db_d;
    logic [DB_W-1:0]  dbc_q, dbc_d;
    state_t           st_q, st_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ev_l;

    // Sync flops idle at the raw released level so reset reads as "not pressed".
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1_q  <= RAW_IDLE;
        s2_q  <= RAW_IDLE;
        db_q  <= 1'b0;
        dbc_q <= '0;
        st_q  <= S_IDLE;
        tmr_q <= '0;
      end else begin
        s1_q  <= raw[g];
        s2_q  <= s1_q;
        db_q  <= db_d;
        dbc_q <= dbc_d;
        st_q  <= st_d;
        tmr_q <= tmr_d;
      end
    end

    assign lvl = s2_q ^ RAW_IDLE;

    always_comb begin
      db_d  = db_q;
      dbc_d = '0;
      if (lvl != db_q) begin
        if (dbc_q == DB_LAST) db_d = lvl;
        else                  dbc_d = dbc_q + DB_W'(1);
      end
    end

    always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      ev_l  = 1'b0;
      case (st_q)
        S_IDLE: begin
          if (db_q) begin
            ev_l  = 1'b1;
            st_d  = S_HOLD;
            tmr_d = '0;
          end
        end
        S_HOLD: begin
          if (!db_q) begin
            st_d = S_IDLE;
          end else if (HOLD_CYCLES != 0) begin
            if (tmr_q == HOLD_LAST) begin
              ev_l  = 1'b1;
              st_d  = S_REPEAT;
              tmr_d = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
        end
        S_REPEAT: begin
          if (!db_q) begin
            st_d = S_IDLE;
          end else if (tmr_q == REP_LAST) begin
            ev_l  = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: st_d = S_IDLE;
      endcase
    end

    assign ev[g] = ev_l;
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             up_q, up_d, dn_q, dn_d, wr_q, wr_d;
  logic [WIDTH:0]   sum, diff;

  // The extra top bit is the carry (up) or borrow (down) out of the count.
  assign sum  = {1'b0, count_q} + STEP_X;
  assign diff = {1'b0, count_q} - STEP_X;

  always_comb begin
    count_d = count_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wr_d    = 1'b0;
    if (ev[0] && !ev[1]) begin
      up_d = 1'b1;
      if (SATURATE != 0) begin
        count_d = sum[WIDTH] ? CNT_MAX : sum[WIDTH-1:0];
      end else begin
        count_d = sum[WIDTH-1:0];
        wr_d    = sum[WIDTH];
      end
    end else if (ev[1] && !ev[0]) begin
      dn_d = 1'b1;
      if (SATURATE != 0) begin
        count_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      end else begin
        count_d = diff[WIDTH-1:0];
        wr_d    = diff[WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wr_q    <= wr_d;
    end
  end

  assign count    = count_q;
  assign up_pulse = up_q;
  assign dn_pulse = dn_q;
  assign wrapped  = wr_q;
  assign at_max   = (count_q == CNT_MAX);
  assign at_min   = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Bench for updown_counter_ctrl: a wrap-mode and a saturate-mode instance share the
// buttons and are compared every cycle against a behavioural press/repeat model.
module tb_updown_counter_ctrl;
  localparam int W    = 4;
  localparam int STEP = 1;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam int MAXV = (1 << W) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic press_up = 1'b0, press_dn = 1'b0;
  logic btn_up, btn_down;
  logic [W-1:0] d_cnt [2];
  logic d_up [2], d_dn [2], d_wr [2], d_max [2], d_min [2];

  assign btn_up   = ~press_up;
  assign btn_down = ~press_dn;

  always #5 clock = ~clock;

  updown_counter_ctrl #(.WIDTH(W), .STEP(STEP), .SATURATE(0), .ACTIVE_LOW(1),
    .DEBOUNCE_LIMIT(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) u_wrap (
    .clock(clock), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .count(d_cnt[0]), .up_pulse(d_up[0]), .dn_pulse(d_dn[0]), .wrapped(d_wr[0]),
    .at_max(d_max[0]), .at_min(d_min[0]));

  updown_counter_ctrl #(.WIDTH(W), .STEP(STEP), .SATURATE(1), .ACTIVE_LOW(1),
    .DEBOUNCE_LIMIT(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) u_sat (
    .clock(clock), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .count(d_cnt[1]), .up_pulse(d_up[1]), .dn_pulse(d_dn[1]), .wrapped(d_wr[1]),
    .at_max(d_max[1]), .at_min(d_min[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Model: per button, raw -> 2-cycle delay -> debounce run length -> press age.
  // Events fire at age 0, HOLD, HOLD+REP, HOLD+2*REP, ... while debounced-pressed.
  int m_s1 [2], m_s2 [2], m_db [2], m_run [2], m_age [2];
  int m_cnt [2];
  bit m_up [2], m_dn [2], m_wr [2];

  always @(posedge clock or negedge reset_n) begin : model
    bit ev [2];
    int raw [2];
    int lvl, ndb, nv;
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_db[b] = 0; m_run[b] = 0; m_age[b] = 0;
        m_cnt[b] = 0; m_up[b] = 0; m_dn[b] = 0; m_wr[b] = 0;
      end
    end else begin
      raw[0] = int'(btn_up);
      raw[1] = int'(btn_down);
      for (int b = 0; b < 2; b++)
        ev[b] = (m_db[b] == 1) && (m_age[b] == 0 ||
                (HOLD > 0 && m_age[b] >= HOLD && (m_age[b] - HOLD) % REP == 0));
      for (int k = 0; k < 2; k++) begin
        m_up[k] = ev[0] && !ev[1];
        m_dn[k] = ev[1] && !ev[0];
        m_wr[k] = 0;
        if (m_up[k]) begin
          nv = m_cnt[k] + STEP;
          if (k == 1) m_cnt[k] = (nv > MAXV) ? MAXV : nv;
          else begin m_wr[k] = (nv > MAXV); m_cnt[k] = nv % (MAXV + 1); end
        end else if (m_dn[k]) begin
          nv = m_cnt[k] - STEP;
          if (k == 1) m_cnt[k] = (nv < 0) ? 0 : nv;
          else begin m_wr[k] = (nv < 0); m_cnt[k] = (nv + MAXV + 1) % (MAXV + 1); end
        end
      end
      for (int b = 0; b < 2; b++) begin
        lvl = (m_s2[b] == 0) ? 1 : 0;
        ndb = m_db[b];
        if (lvl != m_db[b]) begin
          if (m_run[b] + 1 == DEB) begin ndb = lvl; m_run[b] = 0; end
          else m_run[b] = m_run[b] + 1;
        end else begin
          m_run[b] = 0;
        end
        m_age[b] = (m_db[b] == 1 && ndb == 1) ? m_age[b] + 1 : 0;
        m_db[b] = ndb;
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  int cyc_n = 0;
  int n_up [2], n_dn [2], n_wr [2];
  int dn_times [$];

  always @(posedge clock) cyc_n++;

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      chk("count",   k, int'(d_cnt[k]), m_cnt[k]);
      chk("up_pulse", k, int'(d_up[k]),  int'(m_up[k]));
      chk("dn_pulse", k, int'(d_dn[k]),  int'(m_dn[k]));
      chk("wrapped", k, int'(d_wr[k]),  int'(m_wr[k]));
      chk("at_max",  k, int'(d_max[k]), int'(m_cnt[k] == MAXV));
      chk("at_min",  k, int'(d_min[k]), int'(m_cnt[k] == 0));
      if (d_up[k] === 1'b1) n_up[k]++;
      if (d_dn[k] === 1'b1) n_dn[k]++;
      if (d_wr[k] === 1'b1) n_wr[k]++;
    end
    if (d_dn[0] === 1'b1) dn_times.push_back(cyc_n);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    press_up = u;
    press_dn = d;
    cyc(hold);
    press_up = 1'b0;
    press_dn = 1'b0;
    cyc(14);
  endtask

  int snap_up, snap_dn;

  initial begin
    // Reset asserted with both buttons held.
    press_up = 1'b1;
    press_dn = 1'b1;
    #2 reset_n = 1'b0;
    cyc(3);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_count", k, int'(d_cnt[k]), 0);
      chk("rst_at_min", k, int'(d_min[k]), 1);
      chk("rst_up", k, int'(d_up[k]), 0);
    end
    cyc(1);
    reset_n  = 1'b1;
    press_dn = 1'b0;
    cyc(8);
    press_up = 1'b0;
    cyc(14);
    chk("post_rst_count", 0, int'(d_cnt[0]), 1);
    chk("post_rst_count", 1, int'(d_cnt[1]), 1);
    chk("post_rst_nup", 0, n_up[0], 1);

    // Bounce: level never stays put long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      press_up = ~press_up;
      cyc(2);
    end
    press_up = 1'b0;
    cyc(14);
    chk("bounce_nup", 0, n_up[0], 1);
    chk("bounce_count", 0, int'(d_cnt[0]), 1);

    // Wrap and clamp at the bottom, then wrap back over the top.
    press(1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    chk("wrap_dn_count", 0, int'(d_cnt[0]), 15);
    chk("wrap_dn_nwr", 0, n_wr[0], 1);
    chk("sat_dn_count", 1, int'(d_cnt[1]), 0);
    chk("sat_dn_ndn", 1, n_dn[1], 2);
    chk("sat_nwr", 1, n_wr[1], 0);
    press(1'b1, 1'b0, 8);
    chk("wrap_up_count", 0, int'(d_cnt[0]), 0);
    chk("wrap_up_nwr", 0, n_wr[0], 2);
    chk("sat_up_count", 1, int'(d_cnt[1]), 1);

    // 100-cycle hold: events at ages 0,10,15,...,95 = 19 events.
    press(1'b1, 1'b0, 100);
    chk("hold_count", 0, int'(d_cnt[0]), 3);
    chk("hold_count", 1, int'(d_cnt[1]), 15);
    chk("hold_at_max", 1, int'(d_max[1]), 1);
    chk("hold_nup", 1, n_up[1], 21);
    press(1'b1, 1'b0, 8);
    chk("sat_top_count", 1, int'(d_cnt[1]), 15);
    chk("sat_top_nup", 1, n_up[1], 22);
    chk("sat_top_nwr", 1, n_wr[1], 0);
    chk("wrap_cnt4", 0, int'(d_cnt[0]), 4);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 8);
    chk("pre_rep_count", 0, int'(d_cnt[0]), 8);

    // Auto-repeat down from 8: pulses at ages 0,10,15,20,25.
    dn_times.delete();
    press(1'b0, 1'b1, 28);
    chk("rep_count", 0, int'(d_cnt[0]), 3);
    chk("rep_count", 1, int'(d_cnt[1]), 10);
    chk("rep_npulses", 0, dn_times.size(), 5);
    for (int i = 1; i < dn_times.size() && i < 5; i++)
      chk("rep_gap", i, dn_times[i] - dn_times[i-1], (i == 1) ? HOLD : REP);

    // Simultaneous press from 5 cancels.
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    snap_up = n_up[0];
    snap_dn = n_dn[0];
    press(1'b1, 1'b1, 8);
    chk("sim_count", 0, int'(d_cnt[0]), 5);
    chk("sim_count", 1, int'(d_cnt[1]), 12);
    chk("sim_nup", 0, n_up[0], snap_up);
    chk("sim_ndn", 0, n_dn[0], snap_dn);

    // Reset in the middle of auto-repeat.
    press_up = 1'b1;
    cyc(20);
    reset_n = 1'b0;
    cyc(2);
    press_up = 1'b0;
    reset_n  = 1'b1;
    snap_up  = n_up[0];
    cyc(20);
    chk("rst_rep_count", 0, int'(d_cnt[0]), 0);
    chk("rst_rep_count", 1, int'(d_cnt[1]), 0);
    chk("rst_rep_nup", 0, n_up[0], snap_up);

    // Randomised traffic with occasional resets.
    for (int s = 0; s < 150; s++) begin
      press_up = 1'($urandom_range(0, 1));
      press_dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
      end
      cyc($urandom_range(1, 30));
    end
    press_up = 1'b0;
    press_dn = 1'b0;
    cyc(14);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
